// File: rtl/ternary_dot_accum_if.sv
// Stream bundle for ternary_dot_accum: an input beat channel and a result channel.
// The master drives the beats and out_ready. The slave (the accumulator) drives in_ready and the results.
interface ternary_dot_accum_if #(
  parameter int LANES = 32,
  parameter int ACC_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic             in_last;
  logic [LANES-1:0] in_act;
  logic [LANES-1:0] in_wpos;
  logic [LANES-1:0] in_wneg;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;
  logic [15:0]      out_beats;

  modport master (
    output in_valid, in_last, in_act, in_wpos, in_wneg, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf, out_beats
  );

  modport slave (
    input  in_valid, in_last, in_act, in_wpos, in_wneg, out_ready,
    output in_ready, out_valid, out_sum, out_ovf, out_beats
  );
endinterface

// File: rtl/ternary_dot_accum.sv
// Ternary-weight dot-product accumulator: each beat adds popcount(+1 lanes) - popcount(-1 lanes).
// Optional macro TERNARY_DOT_ACCUM_SAT_EN makes the accumulator saturate instead of wrapping.
module ternary_dot_accum #(
  parameter int LANES = 32,
  parameter int ACC_W = 16
) (
  input logic clk,
  input logic rst_n,
  ternary_dot_accum_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

  localparam int CNT_W = 8;
  localparam int EXT_W = ACC_W + 2;
  localparam logic signed [EXT_W-1:0] ACC_MAX = $signed({3'b000, {(ACC_W-1){1'b1}}});
  localparam logic signed [EXT_W-1:0] ACC_MIN = $signed({3'b111, {(ACC_W-1){1'b0}}});

  state_t state, state_nx;

  logic                    in_ready_int;
  logic                    out_valid_int;
  logic                    accept;
  logic                    start_new;
  logic                    retire;

  logic [CNT_W-1:0]        pos_cnt, neg_cnt;
  logic signed [EXT_W-1:0] partial, base, exact;
  logic                    step_ovf;

  logic signed [ACC_W-1:0] acc, acc_nx;
  logic [15:0]             beats;
  logic                    ovf;

  assign accept    = bus.in_valid & in_ready_int;
  assign start_new = (state != ACCUM);
  assign retire    = (state == OUTPUT) & bus.out_ready;

  // A lane that has both masks set has weight 0. It is excluded from both counts.
  always_comb begin
    pos_cnt = '0;
    neg_cnt = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      pos_cnt = pos_cnt + CNT_W'(bus.in_act[i] & bus.in_wpos[i] & ~bus.in_wneg[i]);
      neg_cnt = neg_cnt + CNT_W'(bus.in_act[i] & bus.in_wneg[i] & ~bus.in_wpos[i]);
    end
  end

  always_comb begin
    partial  = $signed(EXT_W'(pos_cnt)) - $signed(EXT_W'(neg_cnt));
    base     = start_new ? '0 : $signed({{2{acc[ACC_W-1]}}, acc});
    exact    = base + partial;
    step_ovf = (exact > ACC_MAX) || (exact < ACC_MIN);
`ifdef TERNARY_DOT_ACCUM_SAT_EN
    if (exact > ACC_MAX)      acc_nx = ACC_MAX[ACC_W-1:0];
    else if (exact < ACC_MIN) acc_nx = ACC_MIN[ACC_W-1:0];
    else                      acc_nx = exact[ACC_W-1:0];
`else
    acc_nx = exact[ACC_W-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // When OUTPUT retires a result, it goes through the same accept path as IDLE. A new beat in that cycle therefore costs no bubble.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, ACCUM: begin
        if (accept) state_nx = bus.in_last ? OUTPUT : ACCUM;
      end
      OUTPUT: begin
        if (bus.out_ready) begin
          if (accept) state_nx = bus.in_last ? OUTPUT : ACCUM;
          else        state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready_int  = 1'b0;
    out_valid_int = 1'b0;
    if (rst_n) begin
      in_ready_int  = (state != OUTPUT) || bus.out_ready;
      out_valid_int = (state == OUTPUT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      beats <= '0;
      ovf   <= 1'b0;
    end else if (accept) begin
      acc   <= acc_nx;
      ovf   <= (start_new ? 1'b0 : ovf) | step_ovf;
      if (start_new)           beats <= 16'd1;
      else if (beats != '1)    beats <= beats + 16'd1;
    end else if (retire) begin
      acc   <= '0;
      beats <= '0;
      ovf   <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_int;
  assign bus.out_sum   = acc;
  assign bus.out_ovf   = ovf;
  assign bus.out_beats = beats;
endmodule

// File: tb/tb_ternary_dot_accum.sv
// Bench for ternary_dot_accum with two instances: ACC_W=16 (A) and ACC_W=8 (B). Both receive the same stimulus.
// Expected overflow results follow TERNARY_DOT_ACCUM_SAT_EN when that macro is defined.
module tb_ternary_dot_accum;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid, in_last, out_ready;
  logic [31:0] in_act, in_wpos, in_wneg;

  ternary_dot_accum_if #(.LANES(32), .ACC_W(16)) ifa ();
  ternary_dot_accum_if #(.LANES(32), .ACC_W(8))  ifb ();

  assign ifa.in_valid = in_valid;  assign ifb.in_valid = in_valid;
  assign ifa.in_last  = in_last;   assign ifb.in_last  = in_last;
  assign ifa.in_act   = in_act;    assign ifb.in_act   = in_act;
  assign ifa.in_wpos  = in_wpos;   assign ifb.in_wpos  = in_wpos;
  assign ifa.in_wneg  = in_wneg;   assign ifb.in_wneg  = in_wneg;
  assign ifa.out_ready = out_ready; assign ifb.out_ready = out_ready;

  ternary_dot_accum #(.LANES(32), .ACC_W(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  ternary_dot_accum #(.LANES(32), .ACC_W(8))  dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic l, input logic [31:0] a, input logic [31:0] p,
                        input logic [31:0] n, input logic ord);
    in_valid = v; in_last = l; in_act = a; in_wpos = p; in_wneg = n; out_ready = ord;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic v, input int s, input int b, input logic o);
    chk({tag, "_valid"}, ifa.out_valid, v);
    chk({tag, "_sum"}, $signed(ifa.out_sum), s);
    chk({tag, "_beats"}, ifa.out_beats, b);
    chk({tag, "_ovf"}, ifa.out_ovf, o);
  endtask

  // Reference step: the exact sum, then wrap or clamp to a signed w-bit value.
  function automatic void acc_step(input int w, input int acc, input int p, output int res, output bit ov);
    int lo, hi, ex, m;
    lo = -(1 << (w - 1));
    hi = (1 << (w - 1)) - 1;
    m  = 1 << w;
    ex = acc + p;
    ov = (ex > hi) || (ex < lo);
`ifdef TERNARY_DOT_ACCUM_SAT_EN
    res = (ex > hi) ? hi : (ex < lo) ? lo : ex;
`else
    res = (((ex - lo) % m) + m) % m + lo;
`endif
  endfunction

  typedef struct {
    logic [31:0] act, pos, neg;
    logic        last;
    logic        exp_valid;
    int          exp_sum;
    int          exp_beats;
  } vec_t;

  vec_t tbl[7];

  bit m_out, m_mid;
  int m_acc[2];
  bit m_ovf[2];
  int m_beats;
  int widths[2] = '{16, 8};

  initial begin
    set_in(0, 0, '0, '0, '0, 0);
    #2;
    chk("rst_valid", ifa.out_valid, 0);
    chk("rst_ready", ifa.in_ready, 0);
    chk("rst_sum", $signed(ifa.out_sum), 0);
    chk("rst_beats", ifa.out_beats, 0);
    chk("rst_ovf", ifa.out_ovf, 0);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", ifa.in_ready, 1);

    tbl[0] = '{32'hFFFFFFFF, 32'h0000FFFF, 32'h00FF0000, 1'b1, 1'b1, 8, 1};
    tbl[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 0, 1};
    tbl[2] = '{32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, -32, 1};
    tbl[3] = '{32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, -64, 2};
    tbl[4] = '{32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b1, -96, 3};
    tbl[5] = '{32'h000000FF, 32'h0000000F, 32'h000000F3, 1'b1, 1'b1, -2, 1};
    tbl[6] = '{32'h0000000F, 32'h0000000F, 32'h00000000, 1'b1, 1'b1, 4, 1};
    for (int i = 0; i < 7; i++) begin
      set_in(1, tbl[i].last, tbl[i].act, tbl[i].pos, tbl[i].neg, 1);
      #1;
      chk($sformatf("tbl%0d_ready", i), ifa.in_ready, 1);
      tick();
      chk_a($sformatf("tbl%0d", i), tbl[i].exp_valid, tbl[i].exp_sum, tbl[i].exp_beats, 0);
    end
    set_in(0, 0, '0, '0, '0, 1);
    tick();
    chk_a("retire_idle", 0, 0, 0, 0);

    // Stall the consumer while the producer already offers the next vector.
    set_in(1, 1, 32'h7F, 32'h7F, '0, 0);
    tick();
    chk_a("stall_first", 1, 7, 1, 0);
    set_in(1, 1, 32'h1F, 32'h1F, '0, 0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("stall%0d_ready", i), ifa.in_ready, 0);
      tick();
      chk_a($sformatf("stall%0d", i), 1, 7, 1, 0);
    end
    out_ready = 1'b1;
    #1;
    chk("stall_release_ready", ifa.in_ready, 1);
    tick();
    chk_a("back_to_back", 1, 5, 1, 0);
    set_in(0, 0, '0, '0, '0, 1);
    tick();
    chk_a("stall_retire", 0, 0, 0, 0);

    // Five beats of +32 overflow the 8-bit instance on the fourth step.
    for (int k = 1; k <= 5; k++) begin
      set_in(1, k == 5, '1, '1, '0, 1);
      tick();
      chk($sformatf("ovf%0d_sum_a", k), $signed(ifa.out_sum), 32 * k);
      chk($sformatf("ovf%0d_flag_b", k), ifb.out_ovf, k >= 4);
    end
`ifdef TERNARY_DOT_ACCUM_SAT_EN
    chk("ovf_sum_b", $signed(ifb.out_sum), 127);
`else
    chk("ovf_sum_b", $signed(ifb.out_sum), -96);
`endif
    chk("ovf_beats_b", ifb.out_beats, 5);
    chk("ovf_valid_b", ifb.out_valid, 1);
    chk("ovf_flag_a", ifa.out_ovf, 0);
    set_in(0, 0, '0, '0, '0, 1);
    tick();
    chk("ovf_cleared_b", ifb.out_ovf, 0);

    // Reset arriving in the middle of a vector.
    set_in(1, 0, 32'hF, 32'hF, '0, 1);
    tick();
    tick();
    chk_a("mid_two_beats", 0, 8, 2, 0);
    set_in(0, 0, '0, '0, '0, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", ifa.in_ready, 0);
    chk_a("mid_rst", 0, 0, 0, 0);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    set_in(1, 1, 32'h7, 32'h7, '0, 1);
    #1;
    chk("mid_rel_ready", ifa.in_ready, 1);
    tick();
    chk_a("mid_after", 1, 3, 1, 0);
    set_in(0, 0, '0, '0, '0, 1);
    tick();
    chk_a("mid_retire", 0, 0, 0, 0);

    // Random traffic against the reference model.
    m_out = 0; m_mid = 0; m_beats = 0;
    for (int k = 0; k < 2; k++) begin m_acc[k] = 0; m_ovf[k] = 0; end
    for (int c = 0; c < 400; c++) begin
      logic v, l, ord, rdy;
      logic [31:0] a, p, n;
      int mode, part, r;
      bit ov;
      v = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 3) == 0);
      ord = ($urandom_range(0, 2) != 0);
      mode = $urandom_range(0, 3);
      if (mode == 0)      begin a = '1; p = '1; n = '0; end
      else if (mode == 1) begin a = '1; p = '0; n = '1; end
      else                begin a = $urandom; p = $urandom; n = $urandom; end
      set_in(v, l, a, p, n, ord);
      #1;
      rdy = !m_out || ord;
      chk("rnd_ready", ifa.in_ready, rdy);
      part = $countones(a & p & ~n) - $countones(a & n & ~p);
      if (v && rdy) begin
        if (!m_mid) begin
          m_beats = 0;
          for (int k = 0; k < 2; k++) begin m_acc[k] = 0; m_ovf[k] = 0; end
        end
        for (int k = 0; k < 2; k++) begin
          acc_step(widths[k], m_acc[k], part, r, ov);
          m_acc[k] = r;
          m_ovf[k] = m_ovf[k] | ov;
        end
        if (m_beats < 65535) m_beats++;
        m_mid = !l;
        m_out = l;
      end else if (m_out && ord) begin
        m_out = 0; m_beats = 0;
        for (int k = 0; k < 2; k++) begin m_acc[k] = 0; m_ovf[k] = 0; end
      end
      tick();
      chk("rnd_valid", ifa.out_valid, m_out);
      chk("rnd_sum_a", $signed(ifa.out_sum), m_acc[0]);
      chk("rnd_sum_b", $signed(ifb.out_sum), m_acc[1]);
      chk("rnd_ovf_a", ifa.out_ovf, m_ovf[0]);
      chk("rnd_ovf_b", ifb.out_ovf, m_ovf[1]);
      chk("rnd_beats", ifa.out_beats, m_beats);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ternary_dot_accum.md
TERNARY_DOT_ACCUM -- requirements
Module: ternary_dot_accum

Interface
REQ-001 SHALL have parameter LANES, default 32, meaning lanes per input beat (2..64).
REQ-002 SHALL have parameter ACC_W, default 16, meaning signed accumulator and result width (8..32).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  input beat valid.
REQ-006 SHALL have port in_ready  output  1  block accepts beat.
REQ-007 SHALL have port in_last  input  1  beat is final beat of vector.
REQ-008 SHALL have port in_act  input  LANES  binary activations, 1 = active.
REQ-009 SHALL have port in_wpos  input  LANES  per-lane weight +1 mask.
REQ-010 SHALL have port in_wneg  input  LANES  per-lane weight -1 mask.
REQ-011 SHALL have port out_valid  output  1  result valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result.
REQ-013 SHALL have port out_sum  output  ACC_W  signed two's-complement dot product.
REQ-014 SHALL have port out_ovf  output  1  sticky overflow flag for current vector.
REQ-015 SHALL have port out_beats  output  16  beats accumulated into current vector.

Function
REQ-016 SHALL compute per-beat partial = popcount(in_act & in_wpos & ~in_wneg) - popcount(in_act & in_wneg & ~in_wpos); lane with both masks set contributes 0.
REQ-017 SHALL accept a beat when in_valid and in_ready are both high on a rising edge.
REQ-018 SHALL implement states IDLE, ACCUM, OUTPUT; in_ready = 1 in IDLE/ACCUM, = out_ready in OUTPUT, purely from state and out_ready.
REQ-019 IDLE/ACCUM accept: IDLE loads acc = partial, beats = 1, ovf = 0; ACCUM adds partial, beats += 1; next state OUTPUT if in_last else ACCUM.
REQ-020 SHALL assert out_valid only in OUTPUT; out_sum, out_ovf, out_beats held stable while out_valid and not out_ready.
REQ-021 OUTPUT with out_ready and no accepted beat: next state IDLE, acc/beats/ovf cleared.
REQ-022 OUTPUT with out_ready and accepted beat (same cycle): result retired, new vector starts as in IDLE accept; no bubble.
REQ-023 Latency: last beat accepted at edge t -> out_valid high from edge t (registered), sum including that beat; one cycle minimum per beat.
REQ-024 Overflow: out_ovf SHALL set when any accumulation step's exact result leaves [-2^(ACC_W-1), 2^(ACC_W-1)-1]; sticky until vector retired.
REQ-025 out_beats SHALL saturate at 65535 and not wrap.
REQ-026 out_sum outside OUTPUT reflects the accumulator; consumers SHALL rely on it only when out_valid.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, acc 0, out_sum 0, out_ovf 0, out_beats 0, out_valid 0, in_ready 0.
REQ-028 Reset mid-vector SHALL discard partial accumulation; first beat after release starts a new vector.
REQ-029 in_ready SHALL be 1 on first edge after rst_n deasserted.

Configuration
REQ-030 Macro TERNARY_DOT_ACCUM_SAT_EN defined: accumulator saturates to max/min of ACC_W on overflow, out_ovf still set.
REQ-031 Macro undefined: accumulator wraps modulo 2^ACC_W; out_ovf set per REQ-024.

Verification
REQ-032 LANES=32, act=FFFFFFFF, wpos=0000FFFF, wneg=00FF0000, last=1 -> next cycle out_valid=1, out_sum=+8, out_beats=1, out_ovf=0.
REQ-033 act=FFFFFFFF, wpos=wneg=FFFFFFFF, last=1 -> out_sum=0, out_ovf=0.
REQ-034 Three beats act=FFFFFFFF, wpos=0, wneg=FFFFFFFF, last on third -> out_sum=-96, out_beats=3.
REQ-035 ACC_W=8, five beats partial +32 -> wrap build: out_sum=-96, out_ovf=1; SAT_EN build: out_sum=127, out_ovf=1.
REQ-036 Hold out_ready=0 four cycles -> outputs stable, in_ready=0; then out_ready=1 with single-beat vector partial +5 same cycle -> next cycle out_valid=1, out_sum=+5, no idle cycle.
REQ-037 Two beats +4 accepted, pulse rst_n low mid-vector -> out_valid=0, in_ready=0 during reset; after release single beat +3 last -> out_sum=+3, out_beats=1.
